// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//
// Shared constants for the 16-point FFT/IFFT core.
//
//   FFT_N          total signed fixed-point width of each re/im word
//   FFT_Q          number of fractional bits (Q8, 1.0 = 16'h0100)
//   ONE            fixed-point 1.0
//   TWIDDLE_RE/IM  Q8 values of W16^k = exp(-j*2*pi*k/16), k = 0..7
//   SCALE_SHIFT    extra right shift applied per butterfly stage
//
// Configuration macro: IFFT_SCALE_EN
//   defined   -> every IFFT butterfly divides its results by 2 (SCALE_SHIFT = 1),
//                so four stages give the 1/16 IFFT normalisation.
//   undefined -> no scaling (SCALE_SHIFT = 0); headroom is the caller's job.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int FFT_Q = 8;

    localparam logic signed [FFT_N-1:0] ONE = 16'sh0100;

    // Twiddles are rounded to the nearest Q8 code. The imaginary part is
    // -sin, because W16^k rotates clockwise for the forward transform.
    localparam logic signed [FFT_N-1:0] TWIDDLE_RE [0:7] = '{
        16'sh0100, 16'sh00ED, 16'sh00B5, 16'sh0062,
        16'sh0000, 16'shFF9E, 16'shFF4B, 16'shFF13
    };

    localparam logic signed [FFT_N-1:0] TWIDDLE_IM [0:7] = '{
        16'sh0000, 16'shFF9E, 16'shFF4B, 16'shFF13,
        16'shFF00, 16'shFF13, 16'shFF4B, 16'shFF9E
    };

    // The scaled build shifts both butterfly outputs by one extra bit. Ports
    // and latency are the same in both builds, so only this constant changes.
`ifdef IFFT_SCALE_EN
    localparam int SCALE_SHIFT = 1;
`else
    localparam int SCALE_SHIFT = 0;
`endif

endpackage : fft_pkg

// File: rtl/cmul_conj_pipe.sv
// ---------------------------------------------------------------------------
// cmul_conj_pipe
//
// One-register-stage complex multiply of a difference term d by the
// conjugate of a twiddle W. The result is kept at full precision:
//   p_re = d_re*w_re + d_im*w_im
//   p_im = d_im*w_re - d_re*w_im
//
// Ports
//   clk_i    in   1       rising-edge clock
//   rst_n_i  in   1       asynchronous reset, active low; clears the product
//   en_i     in   1       load enable; when low the product register holds
//   d_re_i   in   N+1     real part of d (signed)
//   d_im_i   in   N+1     imaginary part of d (signed)
//   w_re_i   in   N       real part of W (signed)
//   w_im_i   in   N       imaginary part of W (signed, conjugated here)
//   p_re_o   out  2N+2    registered real part of d*conj(W)
//   p_im_o   out  2N+2    registered imaginary part of d*conj(W)
// ---------------------------------------------------------------------------
module cmul_conj_pipe #(
    parameter int N = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           en_i,
    input  logic [N:0]     d_re_i,
    input  logic [N:0]     d_im_i,
    input  logic [N-1:0]   w_re_i,
    input  logic [N-1:0]   w_im_i,
    output logic [2*N+1:0] p_re_o,
    output logic [2*N+1:0] p_im_o
);

    logic signed [2*N+1:0] dReExt;
    logic signed [2*N+1:0] dImExt;
    logic signed [2*N+1:0] wReExt;
    logic signed [2*N+1:0] wImExt;
    logic signed [2*N+1:0] pRe_d;
    logic signed [2*N+1:0] pIm_d;
    logic signed [2*N+1:0] pRe_q;
    logic signed [2*N+1:0] pIm_q;

    // All operands are sign-extended to the product width first. A 2N+2 bit
    // multiply of the extended operands is then exact, because the true sum
    // of two (N+1)x(N) products always fits in 2N+2 bits.
    always_comb begin
        dReExt = {{(N+1){d_re_i[N]}}, d_re_i};
        dImExt = {{(N+1){d_im_i[N]}}, d_im_i};
        wReExt = {{(N+2){w_re_i[N-1]}}, w_re_i};
        wImExt = {{(N+2){w_im_i[N-1]}}, w_im_i};

        // Multiplying by conj(W) flips the sign of every w_im term.
        pRe_d = dReExt * wReExt + dImExt * wImExt;
        pIm_d = dImExt * wReExt - dReExt * wImExt;
    end

    // Product register. It holds while the downstream stage is stalled.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pRe_q <= '0;
            pIm_q <= '0;
        end else if (en_i) begin
            pRe_q <= pRe_d;
            pIm_q <= pIm_d;
        end
    end

    assign p_re_o = pRe_q;
    assign p_im_o = pIm_q;

endmodule : cmul_conj_pipe

// File: rtl/ifft_butterfly2_pipe.sv
// ---------------------------------------------------------------------------
// ifft_butterfly2_pipe
//
// Pipelined radix-2 inverse (DIF) butterfly for the IFFT return path of the
// 16-point FFT core:
//   out0 = (a + b) * s
//   out1 = ((a - b) * conj(W)) * s
// where s = 1, or s = 1/2 when the macro IFFT_SCALE_EN is defined.
// The pipeline has three register stages with valid/ready flow control, so
// IFFT stages can be chained and stalled. Latency is 3 clocks, and throughput
// is one pair per clock.
//
// Configuration macro: IFFT_SCALE_EN (see fft_pkg::SCALE_SHIFT)
//
// Ports
//   i_clk           in   1   rising-edge clock
//   i_rst           in   1   asynchronous reset, active low
//   i_valid         in   1   input pair and twiddle are valid
//   o_ready         out  1   block accepts input this cycle
//   i_last          in   1   frame marker, carried with the data
//   i_in0_re/im     in   N   operand a
//   i_in1_re/im     in   N   operand b
//   i_twiddle_re/im in   N   twiddle W (conjugated internally)
//   o_valid         out  1   outputs valid
//   i_ready         in   1   downstream accepts
//   o_last          out  1   delayed frame marker
//   o_out0_re/im    out  N   (a+b)*s
//   o_out1_re/im    out  N   (a-b)*conj(W)*s
// ---------------------------------------------------------------------------
module ifft_butterfly2_pipe
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int Q = FFT_Q
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_last,
    input  logic [N-1:0] i_in0_re,
    input  logic [N-1:0] i_in0_im,
    input  logic [N-1:0] i_in1_re,
    input  logic [N-1:0] i_in1_im,
    input  logic [N-1:0] i_twiddle_re,
    input  logic [N-1:0] i_twiddle_im,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last,
    output logic [N-1:0] o_out0_re,
    output logic [N-1:0] o_out0_im,
    output logic [N-1:0] o_out1_re,
    output logic [N-1:0] o_out1_im
);

    // Stage load enables
    logic loadS1;
    logic loadS2;
    logic loadS3;

    // Stage 1: sum, difference, twiddle
    logic         s1Valid_q;
    logic         s1Last_q;
    logic [N:0]   s1SumRe_d;
    logic [N:0]   s1SumIm_d;
    logic [N:0]   s1DiffRe_d;
    logic [N:0]   s1DiffIm_d;
    logic [N:0]   s1SumRe_q;
    logic [N:0]   s1SumIm_q;
    logic [N:0]   s1DiffRe_q;
    logic [N:0]   s1DiffIm_q;
    logic [N-1:0] s1TwRe_q;
    logic [N-1:0] s1TwIm_q;

    // Stage 2: product (in cmul_conj_pipe) and delayed sum
    logic           s2Valid_q;
    logic           s2Last_q;
    logic [N:0]     s2SumRe_q;
    logic [N:0]     s2SumIm_q;
    logic [2*N+1:0] s2ProdRe;
    logic [2*N+1:0] s2ProdIm;

    // Stage 3: output registers
    logic         s3Valid_q;
    logic         s3Last_q;
    logic [N-1:0] s3Out0Re_d;
    logic [N-1:0] s3Out0Im_d;
    logic [N-1:0] s3Out1Re_d;
    logic [N-1:0] s3Out1Im_d;
    logic [N-1:0] s3Out0Re_q;
    logic [N-1:0] s3Out0Im_q;
    logic [N-1:0] s3Out1Re_q;
    logic [N-1:0] s3Out1Im_q;

    // A stage loads when it is empty or when the stage after it is moving.
    // This ripples back from the output, so a full pipeline keeps streaming
    // while downstream is ready. The resulting combinational path from
    // i_ready to o_ready is intended.
    assign loadS3  = !s3Valid_q || i_ready;
    assign loadS2  = !s2Valid_q || loadS3;
    assign loadS1  = !s1Valid_q || loadS2;
    assign o_ready = loadS1;

    // Stage 1 arithmetic. Both operands get one extra sign bit, so a+b and
    // a-b cannot overflow.
    always_comb begin
        s1SumRe_d  = {i_in0_re[N-1], i_in0_re} + {i_in1_re[N-1], i_in1_re};
        s1SumIm_d  = {i_in0_im[N-1], i_in0_im} + {i_in1_im[N-1], i_in1_im};
        s1DiffRe_d = {i_in0_re[N-1], i_in0_re} - {i_in1_re[N-1], i_in1_re};
        s1DiffIm_d = {i_in0_im[N-1], i_in0_im} - {i_in1_im[N-1], i_in1_im};
    end

    // Stage 1 registers. The twiddle travels with its pair. The frame marker
    // is qualified with i_valid, so a bubble never carries a stray last flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1Valid_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            s1SumRe_q  <= '0;
            s1SumIm_q  <= '0;
            s1DiffRe_q <= '0;
            s1DiffIm_q <= '0;
            s1TwRe_q   <= '0;
            s1TwIm_q   <= '0;
        end else if (loadS1) begin
            s1Valid_q  <= i_valid;
            s1Last_q   <= i_valid && i_last;
            s1SumRe_q  <= s1SumRe_d;
            s1SumIm_q  <= s1SumIm_d;
            s1DiffRe_q <= s1DiffRe_d;
            s1DiffIm_q <= s1DiffIm_d;
            s1TwRe_q   <= i_twiddle_re;
            s1TwIm_q   <= i_twiddle_im;
        end
    end

    // Stage 2 complex multiply by conj(W). It shares the stage-2 enable, so
    // the product stays aligned with the delayed sum below.
    cmul_conj_pipe #(
        .N (N)
    ) u_cmul (
        .clk_i   (i_clk),
        .rst_n_i (i_rst),
        .en_i    (loadS2),
        .d_re_i  (s1DiffRe_q),
        .d_im_i  (s1DiffIm_q),
        .w_re_i  (s1TwRe_q),
        .w_im_i  (s1TwIm_q),
        .p_re_o  (s2ProdRe),
        .p_im_o  (s2ProdIm)
    );

    // Stage 2 registers: delayed sum plus valid and frame marker.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s2Valid_q <= 1'b0;
            s2Last_q  <= 1'b0;
            s2SumRe_q <= '0;
            s2SumIm_q <= '0;
        end else if (loadS2) begin
            s2Valid_q <= s1Valid_q;
            s2Last_q  <= s1Last_q;
            s2SumRe_q <= s1SumRe_q;
            s2SumIm_q <= s1SumIm_q;
        end
    end

    // Stage 3 alignment. The product drops its Q fractional bits, and both
    // outputs take the optional extra /2. Arithmetic shifts truncate toward
    // -inf. Keeping only the low N bits gives two's-complement wrap, with no
    // saturation.
    always_comb begin
        s3Out0Re_d = N'($signed(s2SumRe_q) >>> SCALE_SHIFT);
        s3Out0Im_d = N'($signed(s2SumIm_q) >>> SCALE_SHIFT);
        s3Out1Re_d = N'($signed(s2ProdRe) >>> (Q + SCALE_SHIFT));
        s3Out1Im_d = N'($signed(s2ProdIm) >>> (Q + SCALE_SHIFT));
    end

    // Stage 3 registers drive the outputs directly.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s3Valid_q  <= 1'b0;
            s3Last_q   <= 1'b0;
            s3Out0Re_q <= '0;
            s3Out0Im_q <= '0;
            s3Out1Re_q <= '0;
            s3Out1Im_q <= '0;
        end else if (loadS3) begin
            s3Valid_q  <= s2Valid_q;
            s3Last_q   <= s2Last_q;
            s3Out0Re_q <= s3Out0Re_d;
            s3Out0Im_q <= s3Out0Im_d;
            s3Out1Re_q <= s3Out1Re_d;
            s3Out1Im_q <= s3Out1Im_d;
        end
    end

    assign o_valid   = s3Valid_q;
    assign o_last    = s3Last_q;
    assign o_out0_re = s3Out0Re_q;
    assign o_out0_im = s3Out0Im_q;
    assign o_out1_re = s3Out1Re_q;
    assign o_out1_im = s3Out1Im_q;

endmodule : ifft_butterfly2_pipe

// File: tb/tb_ifft_butterfly2_pipe.sv
// ---------------------------------------------------------------------------
// tb_ifft_butterfly2_pipe
//
// Testbench for ifft_butterfly2_pipe. Each accepted input pushes its expected
// response into a scoreboard queue. A monitor pops an entry and compares it on
// every output handshake. Expected values follow the build, so the bench also
// covers the IFFT_SCALE_EN variant.
// ---------------------------------------------------------------------------
module tb_ifft_butterfly2_pipe;
    import fft_pkg::*;

`ifdef IFFT_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    typedef struct {
        logic [15:0] o0re;
        logic [15:0] o0im;
        logic [15:0] o1re;
        logic [15:0] o1im;
        logic        last;
        int          accCyc;
        bit          chkLat;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_last;
    logic [15:0] i_in0_re, i_in0_im, i_in1_re, i_in1_im;
    logic [15:0] i_twiddle_re, i_twiddle_im;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;
    logic [15:0] o_out0_re, o_out0_im, o_out1_re, o_out1_im;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   outCount = 0;
    exp_t sbQ[$];

    ifft_butterfly2_pipe dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_last       (i_last),
        .i_in0_re     (i_in0_re),
        .i_in0_im     (i_in0_im),
        .i_in1_re     (i_in1_re),
        .i_in1_im     (i_in1_im),
        .i_twiddle_re (i_twiddle_re),
        .i_twiddle_im (i_twiddle_im),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_last       (o_last),
        .o_out0_re    (o_out0_re),
        .o_out0_im    (o_out0_im),
        .o_out1_re    (o_out1_re),
        .o_out1_im    (o_out1_im)
    );

    // 10 ns clock, plus a free-running edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts the check and reports any failure.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Hand-computed expected response.
    function automatic exp_t handExp(input logic [15:0] o0re, input logic [15:0] o0im,
                                     input logic [15:0] o1re, input logic [15:0] o1im);
        exp_t e;
        e.o0re = o0re; e.o0im = o0im; e.o1re = o1re; e.o1im = o1im;
        e.last = 1'b0; e.accCyc = 0; e.chkLat = 1'b0;
        return e;
    endfunction

    // Reference butterfly in plain integer arithmetic, for the longer streams.
    function automatic exp_t modelExp(input logic signed [15:0] a0re, input logic signed [15:0] a0im,
                                      input logic signed [15:0] a1re, input logic signed [15:0] a1im,
                                      input logic signed [15:0] wre,  input logic signed [15:0] wim);
        exp_t   e;
        longint sRe, sIm, dRe, dIm, pRe, pIm;
        int     sh;
        sh  = SCALED ? 1 : 0;
        sRe = longint'(a0re) + longint'(a1re);
        sIm = longint'(a0im) + longint'(a1im);
        dRe = longint'(a0re) - longint'(a1re);
        dIm = longint'(a0im) - longint'(a1im);
        pRe = dRe * longint'(wre) + dIm * longint'(wim);
        pIm = dIm * longint'(wre) - dRe * longint'(wim);
        e.o0re = 16'(sRe >>> sh);
        e.o0im = 16'(sIm >>> sh);
        e.o1re = 16'(pRe >>> (8 + sh));
        e.o1im = 16'(pIm >>> (8 + sh));
        e.last = 1'b0; e.accCyc = 0; e.chkLat = 1'b0;
        return e;
    endfunction

    // Presents one pair and waits (bounded) until it is accepted. The
    // expectation is queued for the edge where the handshake happens.
    // 'waited' returns the number of cycles o_ready was low.
    task automatic applyStimulus(input logic [15:0] a0re, input logic [15:0] a0im,
                                 input logic [15:0] a1re, input logic [15:0] a1im,
                                 input logic [15:0] wre,  input logic [15:0] wim,
                                 input logic last, input exp_t eIn, input bit chkLat,
                                 output int waited);
        exp_t e;
        bit   done;
        e = eIn;
        i_valid = 1'b1; i_last = last;
        i_in0_re = a0re; i_in0_im = a0im; i_in1_re = a1re; i_in1_im = a1im;
        i_twiddle_re = wre; i_twiddle_im = wim;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (o_ready) begin
                e.accCyc = cyc + 1;
                e.chkLat = chkLat;
                e.last   = last;
                sbQ.push_back(e);
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checkOutput("accept_timeout", 32'(waited), 32'd0);
                    done = 1'b1;
                end
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Waits (bounded) until every queued expectation has come out.
    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || o_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", 32'(sbQ.size() == 0), 32'd1);
    endtask

    // Monitor: on every output handshake, pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rst && o_valid && i_ready) begin
                checkOutput("output_expected", 32'(sbQ.size() != 0), 32'd1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("out0_re", 32'(o_out0_re), 32'(e.o0re));
                    checkOutput("out0_im", 32'(o_out0_im), 32'(e.o0im));
                    checkOutput("out1_re", 32'(o_out1_re), 32'(e.o1re));
                    checkOutput("out1_im", 32'(o_out1_im), 32'(e.o1im));
                    checkOutput("last",    32'(o_last),    32'(e.last));
                    if (e.chkLat)
                        checkOutput("latency", 32'(cyc + 1 - e.accCyc), 32'd3);
                end
                outCount++;
            end
        end
    end

    // Hard stop if anything hangs.
    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] global timeout");
    end

    // Directed test sequence.
    initial begin
        exp_t        e;
        int          w0, w1, w2, w4, w5, w6;
        int          outBefore;
        logic [15:0] a0re, a0im, a1re, a1im;

        i_rst = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
        i_in0_re = '0; i_in0_im = '0; i_in1_re = '0; i_in1_im = '0;
        i_twiddle_re = '0; i_twiddle_im = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_o_valid",   32'(o_valid),   32'd0);
        checkOutput("rst_o_last",    32'(o_last),    32'd0);
        checkOutput("rst_out0_re",   32'(o_out0_re), 32'd0);
        checkOutput("rst_out1_im",   32'(o_out1_im), 32'd0);
        @(posedge clk); #1;
        i_rst = 1'b1;
        #1;
        checkOutput("rst_o_ready", 32'(o_ready), 32'd1);

        // Test 1: W = 1, a = 2, b = 1
        $display("[TB] test 1: identity twiddle");
        e = SCALED ? handExp(16'h0180, 16'h0000, 16'h0080, 16'h0000)
                   : handExp(16'h0300, 16'h0000, 16'h0100, 16'h0000);
        applyStimulus(16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, e, 1'b1, w0);
        waitDrain();

        // Test 2: W = -j, a = 1, b = 0
        $display("[TB] test 2: twiddle -j");
        e = SCALED ? handExp(16'h0080, 16'h0000, 16'h0000, 16'h0080)
                   : handExp(16'h0100, 16'h0000, 16'h0000, 16'h0100);
        applyStimulus(16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 1'b0, e, 1'b1, w0);
        waitDrain();

        // Test 5: sum wraps when unscaled; fits when scaled
        $display("[TB] test 5: wrap");
        e = SCALED ? handExp(16'h7F00, 16'h0000, 16'h0000, 16'h0000)
                   : handExp(16'hFE00, 16'h0000, 16'h0000, 16'h0000);
        applyStimulus(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, ONE, 16'h0000, 1'b0, e, 1'b1, w0);
        waitDrain();

        // Test 3: 8 back-to-back pairs, last on the 8th. A latency of 3 for
        // every pair means 8 outputs on consecutive clocks.
        $display("[TB] test 3: back-to-back stream");
        outBefore = outCount;
        for (int i = 0; i < 8; i++) begin
            a0re = 16'(i * 64 + 16);
            a0im = 16'(-i * 32);
            a1re = 16'h0030;
            a1im = 16'(i * 24);
            e = modelExp(a0re, a0im, a1re, a1im, TWIDDLE_RE[i], TWIDDLE_IM[i]);
            applyStimulus(a0re, a0im, a1re, a1im, TWIDDLE_RE[i], TWIDDLE_IM[i], 1'(i == 7), e, 1'b1, w0);
            checkOutput("stream_no_stall", 32'(w0), 32'd0);
        end
        waitDrain();
        checkOutput("stream_out_count", 32'(outCount - outBefore), 32'd8);

        // Test 4: downstream stalled; exactly 3 accepted, then o_ready low
        // until release.
        $display("[TB] test 4: backpressure");
        outBefore = outCount;
        i_ready = 1'b0;
        e = modelExp(16'h0123, 16'h0040, 16'h0011, 16'hFFC0, TWIDDLE_RE[1], TWIDDLE_IM[1]);
        applyStimulus(16'h0123, 16'h0040, 16'h0011, 16'hFFC0, TWIDDLE_RE[1], TWIDDLE_IM[1], 1'b0, e, 1'b0, w0);
        e = modelExp(16'hFF00, 16'h0200, 16'h0100, 16'h0050, TWIDDLE_RE[2], TWIDDLE_IM[2]);
        applyStimulus(16'hFF00, 16'h0200, 16'h0100, 16'h0050, TWIDDLE_RE[2], TWIDDLE_IM[2], 1'b0, e, 1'b0, w1);
        e = modelExp(16'h0300, 16'hFE80, 16'h0020, 16'h0033, TWIDDLE_RE[3], TWIDDLE_IM[3]);
        applyStimulus(16'h0300, 16'hFE80, 16'h0020, 16'h0033, TWIDDLE_RE[3], TWIDDLE_IM[3], 1'b0, e, 1'b0, w2);
        checkOutput("stall_first3_waits", 32'(w0 + w1 + w2), 32'd0);
        fork
            begin
                e = modelExp(16'h0055, 16'h0066, 16'hFFAA, 16'h0010, TWIDDLE_RE[5], TWIDDLE_IM[5]);
                applyStimulus(16'h0055, 16'h0066, 16'hFFAA, 16'h0010, TWIDDLE_RE[5], TWIDDLE_IM[5], 1'b0, e, 1'b0, w4);
                e = modelExp(16'h0400, 16'h0000, 16'h0000, 16'h0400, TWIDDLE_RE[6], TWIDDLE_IM[6]);
                applyStimulus(16'h0400, 16'h0000, 16'h0000, 16'h0400, TWIDDLE_RE[6], TWIDDLE_IM[6], 1'b1, e, 1'b0, w5);
                e = modelExp(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, TWIDDLE_RE[7], TWIDDLE_IM[7]);
                applyStimulus(16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, TWIDDLE_RE[7], TWIDDLE_IM[7], 1'b0, e, 1'b0, w6);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        checkOutput("stall_4th_wait", 32'(w4), 32'd6);
        waitDrain();
        checkOutput("stall_out_count", 32'(outCount - outBefore), 32'd6);

        // Test 6: reset with pairs in flight; nothing stale comes out afterwards.
        $display("[TB] test 6: reset mid-stream");
        e = modelExp(16'h0111, 16'h0222, 16'h0033, 16'h0044, TWIDDLE_RE[1], TWIDDLE_IM[1]);
        applyStimulus(16'h0111, 16'h0222, 16'h0033, 16'h0044, TWIDDLE_RE[1], TWIDDLE_IM[1], 1'b0, e, 1'b0, w0);
        e = modelExp(16'h0555, 16'h0666, 16'h0077, 16'h0088, TWIDDLE_RE[2], TWIDDLE_IM[2]);
        applyStimulus(16'h0555, 16'h0666, 16'h0077, 16'h0088, TWIDDLE_RE[2], TWIDDLE_IM[2], 1'b1, e, 1'b0, w1);
        @(posedge clk); #1;
        checkOutput("pre_rst_o_valid", 32'(o_valid), 32'd1);
        i_rst = 1'b0;
        #1;
        sbQ.delete();
        checkOutput("midrst_o_valid", 32'(o_valid),   32'd0);
        checkOutput("midrst_o_last",  32'(o_last),    32'd0);
        checkOutput("midrst_out0_re", 32'(o_out0_re), 32'd0);
        checkOutput("midrst_out0_im", 32'(o_out0_im), 32'd0);
        checkOutput("midrst_out1_re", 32'(o_out1_re), 32'd0);
        checkOutput("midrst_out1_im", 32'(o_out1_im), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b1;
        #1;
        checkOutput("postrst_o_ready", 32'(o_ready), 32'd1);
        e = modelExp(16'h0240, 16'hFF80, 16'h0040, 16'h0080, TWIDDLE_RE[4], TWIDDLE_IM[4]);
        applyStimulus(16'h0240, 16'hFF80, 16'h0040, 16'h0080, TWIDDLE_RE[4], TWIDDLE_IM[4], 1'b1, e, 1'b1, w0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ifft_butterfly2_pipe
